memory_unit: RTL and testbench

Parametrised, word-addressed unified instruction/data memory for the multicycle CPU. It replaces the phase-driven fetch/load/store memory with two explicit request channels: instruction fetch (`if_*`) and data (`dm_*`). The channels share one single-port array behind an arbiter and a wait-state FSM. Latency is configurable, byte-masked stores are optional, and accesses outside the populated address range are flagged.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/memory_unit_if.sv | 33 +++
 rtl/mem_array.sv | 47 ++++
 rtl/memory_unit.sv | 159 +++++++++++++++
 tb/tb_memory_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory.
package mem_pkg;

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned PADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } state_t;

  typedef logic ch_t;
  localparam ch_t CH_IF = 1'b0;
  localparam ch_t CH_DM = 1'b1;

  // Latched descriptor of the access currently owning the array.
  typedef struct packed {
    ch_t                ch;
    logic               we;
    logic               in_range;
    logic [PADDR_W-1:0] addr;
  } acc_ctrl_t;

  function automatic logic addr_in_range(input logic [PADDR_W-1:0] addr,
                                         input int unsigned        aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Fetch and data request channels plus status of memory_unit.
interface memory_unit_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [31:0]       if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;

  logic              busy;
  logic              err;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  if_rdata, if_valid, dm_rdata, dm_valid, busy, err
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output if_rdata, if_valid, dm_rdata, dm_valid, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM.
// MEMORY_UNIT_BYTE_EN enables per-byte store masking.
module mem_array #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam bit          HAS_INIT = (INIT_FILE != "");

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic unused_init;
  assign unused_init = HAS_INIT;

`ifndef MEMORY_UNIT_BYTE_EN
  logic unused_be;
  assign unused_be = ^be;
`endif

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
`ifdef MEMORY_UNIT_BYTE_EN
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
`else
        mem_q[addr] <= wdata;
`endif
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/memory_unit.sv
// Unified fetch/data memory: data-priority arbiter, wait-state FSM, range check.
// Build option MEMORY_UNIT_BYTE_EN enables byte-masked stores (in mem_array).
module memory_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WAIT_CYC  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  acc_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic [31:0]       acc_addr;
  logic              acc_we;
  logic              arr_wr;
  logic              arr_rd;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.dm_req || bus.if_req) begin
          // Data channel wins; a concurrent fetch simply stays pending.
          if (bus.dm_req) begin
            ctrl_d.ch   = CH_DM;
            ctrl_d.we   = bus.dm_we;
            ctrl_d.addr = bus.dm_addr;
            wdata_d     = bus.dm_wdata;
            be_d        = bus.dm_be;
          end else begin
            ctrl_d.ch   = CH_IF;
            ctrl_d.we   = 1'b0;
            ctrl_d.addr = bus.if_addr;
          end
          ctrl_d.in_range = addr_in_range(ctrl_d.addr, ADDR_W);
          cnt_d   = (WAIT_CYC > 0) ? WCNT_W'(WAIT_CYC - 1) : '0;
          state_d = (WAIT_CYC > 0) ? WAIT : ACC;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACC;
        else             cnt_d   = cnt_q - WCNT_W'(1);
      end
      ACC: begin
        state_d = IDLE;
        err_d   = !ctrl_q.in_range;
        if (ctrl_q.ch == CH_DM) begin
          dm_valid_d = 1'b1;
          if (!ctrl_q.we) dm_rdata_d = ctrl_q.in_range ? arr_rdata : '0;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = ctrl_q.in_range ? arr_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Reads are issued on the edge entering ACC so the word is ready to register
  // on the ACC edge; writes commit on the ACC edge unless reset aborts them.
  always_comb begin
    acc_addr = ctrl_q.addr;
    acc_we   = ctrl_q.we;
    if (state_q == IDLE) begin
      if (bus.dm_req) begin
        acc_addr = bus.dm_addr;
        acc_we   = bus.dm_we;
      end else begin
        acc_addr = bus.if_addr;
        acc_we   = 1'b0;
      end
    end
    arr_wr   = (state_q == ACC) && ctrl_q.we && ctrl_q.in_range && !rst;
    arr_rd   = (state_d == ACC) && !acc_we;
    arr_addr = ADDR_W'(acc_addr);
  end

  mem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem_array (
    .clk   (clk),
    .en    (arr_wr || arr_rd),
    .we    (arr_wr),
    .be    (be_q),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_valid = if_valid_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.dm_valid = dm_valid_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: one instance with 3 wait states, one with none.
module tb_memory_unit;

  localparam int unsigned WC = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  memory_unit_if #(.DATA_W(32)) bus  ();
  memory_unit_if #(.DATA_W(32)) bus0 ();

  memory_unit #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(WC), .INIT_FILE("")) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  memory_unit #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(0), .INIT_FILE("")) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // One access on the chosen DUT; called at a falling edge, returns at the
  // falling edge of the valid cycle with the request already dropped.
  task automatic do_acc(input bit sel0, input bit is_dm, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat, output int busy_n,
                        output logic [31:0] rdata, output logic err);
    logic v;
    if (sel0) begin
      if (is_dm) begin
        bus0.dm_req = 1'b1; bus0.dm_we = we; bus0.dm_addr = addr;
        bus0.dm_wdata = wdata; bus0.dm_be = be;
      end else begin
        bus0.if_req = 1'b1; bus0.if_addr = addr;
      end
    end else begin
      if (is_dm) begin
        bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr;
        bus.dm_wdata = wdata; bus.dm_be = be;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = addr;
      end
    end
    lat = 0; busy_n = 0; v = 1'b0;
    while (lat < 40 && !v) begin
      @(negedge clk);
      lat++;
      v = sel0 ? (is_dm ? bus0.dm_valid : bus0.if_valid)
               : (is_dm ? bus.dm_valid  : bus.if_valid);
      if (sel0 ? bus0.busy : bus.busy) busy_n++;
    end
    if (!v) check("valid_timeout", 32'(v), 32'd1);
    rdata = sel0 ? (is_dm ? bus0.dm_rdata : bus0.if_rdata)
                 : (is_dm ? bus.dm_rdata  : bus.if_rdata);
    err   = sel0 ? bus0.err : bus.err;
    bus0.dm_req = 1'b0; bus0.if_req = 1'b0;
    bus.dm_req  = 1'b0; bus.if_req  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
    check({tag, "_dm_valid"}, 32'(bus.dm_valid), 32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_if_rdata"}, bus.if_rdata,      32'd0);
    check({tag, "_dm_rdata"}, bus.dm_rdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int          lat, bn, dm_t, if_t, nvalid;
    logic [31:0] rd, dm_rd, if_rd, exp_be;
    logic        er;

    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.dm_req = 1'b0;  bus.dm_we = 1'b0;
    bus.dm_addr = '0;   bus.dm_wdata = '0; bus.dm_be = '0;
    bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
    bus0.dm_addr = '0;  bus0.dm_wdata = '0; bus0.dm_be = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Zero wait states: latency 2, busy only in the single cycle before valid.
    do_acc(1'b1, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, lat, bn, rd, er);
    check("wc0_st_lat",  32'(lat), 32'd2);
    check("wc0_st_busy", 32'(bn),  32'd1);
    check("wc0_st_err",  32'(er),  32'd0);
    do_acc(1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 4'hF, lat, bn, rd, er);
    check("wc0_ld_lat",  32'(lat), 32'd2);
    check("wc0_ld_data", rd,       32'hDEADBEEF);
    check("wc0_ld_err",  32'(er),  32'd0);

    // Three wait states: latency 5, busy 4 cycles; loads see preceding stores.
    do_acc(1'b0, 1'b1, 1'b1, 32'd0, 32'h12345678, 4'hF, lat, bn, rd, er);
    check("st0_lat",  32'(lat), 32'd5);
    check("st0_busy", 32'(bn),  32'd4);
    do_acc(1'b0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, lat, bn, rd, er);
    do_acc(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 4'hF, lat, bn, rd, er);
    check("ld5_data", rd,       32'hDEADBEEF);
    check("ld5_lat",  32'(lat), 32'd5);
    check("ld5_err",  32'(er),  32'd0);
    do_acc(1'b0, 1'b1, 1'b1, 32'd6, 32'h0, 4'hF, lat, bn, rd, er);
    check("st_keeps_rdata", rd, 32'hDEADBEEF);

    do_acc(1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 4'h0, lat, bn, rd, er);
    check("fetch_lat",  32'(lat), 32'd5);
    check("fetch_busy", 32'(bn),  32'd4);
    check("fetch_data", rd,       32'h12345678);
    check("fetch_err",  32'(er),  32'd0);

    // Simultaneous requests: data first, fetch follows WC+2 cycles later.
    do_acc(1'b0, 1'b1, 1'b1, 32'd2, 32'h000055AA, 4'hF, lat, bn, rd, er);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'd2;
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    dm_t = 0; if_t = 0; dm_rd = '0; if_rd = '0;
    for (int t = 1; t <= 30 && (dm_t == 0 || if_t == 0); t++) begin
      @(negedge clk);
      if (bus.dm_valid && dm_t == 0) begin dm_t = t; dm_rd = bus.dm_rdata; bus.dm_req = 1'b0; end
      if (bus.if_valid && if_t == 0) begin if_t = t; if_rd = bus.if_rdata; bus.if_req = 1'b0; end
    end
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    check("arb_dm_time", 32'(dm_t), 32'(WC + 2));
    check("arb_if_time", 32'(if_t), 32'(2 * (WC + 2)));
    check("arb_dm_data", dm_rd,     32'h000055AA);
    check("arb_if_data", if_rd,     32'h12345678);

    // Out-of-range: index bits alias address 0, which must stay untouched.
    do_acc(1'b0, 1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, lat, bn, rd, er);
    check("oor_st_lat", 32'(lat), 32'd5);
    check("oor_st_err", 32'(er),  32'd1);
    do_acc(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, lat, bn, rd, er);
    check("oor_ld_data", rd,      32'h0);
    check("oor_ld_err",  32'(er), 32'd1);
    @(negedge clk);
    check("oor_err_pulse", 32'(bus.err), 32'd0);
    do_acc(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 4'hF, lat, bn, rd, er);
    check("addr0_intact", rd,      32'h12345678);
    check("addr0_err",    32'(er), 32'd0);

    // Byte-masked store of zeros over an all-ones word.
`ifdef MEMORY_UNIT_BYTE_EN
    exp_be = 32'hFF00FF00;
`else
    exp_be = 32'h00000000;
`endif
    do_acc(1'b0, 1'b1, 1'b1, 32'd9, 32'hFFFFFFFF, 4'hF, lat, bn, rd, er);
    do_acc(1'b0, 1'b1, 1'b1, 32'd9, 32'h00000000, 4'b0101, lat, bn, rd, er);
    do_acc(1'b0, 1'b1, 1'b0, 32'd9, 32'h0, 4'hF, lat, bn, rd, er);
    check("byte_en_data", rd, exp_be);

    // Reset one cycle after accepting a store aborts it.
    do_acc(1'b0, 1'b1, 1'b1, 32'd7, 32'hAAAAAAAA, 4'hF, lat, bn, rd, er);
    do_acc(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 4'hF, lat, bn, rd, er);
    check("pre_abort_data", rd, 32'hAAAAAAAA);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'd7;
    bus.dm_wdata = 32'h11111111; bus.dm_be = 4'hF;
    nvalid = 0;
    @(negedge clk);
    rst = 1'b1; bus.dm_req = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (t == 2) rst = 1'b0;
      @(negedge clk);
      if (bus.dm_valid) nvalid++;
    end
    check("abort_no_valid", 32'(nvalid), 32'd0);
    check_idle_outputs("post_abort");
    do_acc(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 4'hF, lat, bn, rd, er);
    check("abort_no_write", rd, 32'hAAAAAAAA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
